// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with 3-sample majority voting, feeding a first-word-fall-through
// FIFO that carries per-word parity/framing flags; also reports line breaks and FIFO overruns.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        m_data,
    output logic                        m_parity_err,
    output logic                        m_frame_err,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overrun,
    output logic                        break_det,
    output logic                        busy
);
    localparam int TICK_DIV = CLOCK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SMP_W    = $clog2(OVERSAMPLE);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int WW       = DATA_BITS + 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_A    = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_B    = SMP_W'(OVERSAMPLE / 2);
    localparam logic [SMP_W-1:0] SMP_DEC  = SMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SMP_W-1:0] SMP_END  = SMP_W'(OVERSAMPLE - 1);
    localparam logic [CW-1:0]    DEPTH_L  = CW'(FIFO_DEPTH);

    if (TICK_DIV < 2) begin : g_bad_tick
        $error("uart_rx_fifo: CLOCK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 ||
        STOP_BITS > 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_rx_fifo: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    // Sync flops reset high so a reset release never looks like a start edge.
    logic rx_m, rx_s;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

    state_t               state;
    logic [SMP_W-1:0]     smp_cnt;
    logic [3:0]           bit_cnt;
    logic                 smp_a, smp_b, par_bit, parity_err, frame_err;
    logic [DATA_BITS-1:0] shreg;
    logic                 vote, decide, bit_end, par_exp, is_break, last_stop, push;
    logic [WW-1:0]        push_word;

    assign vote      = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign decide    = tick && smp_cnt == SMP_DEC;
    assign bit_end   = tick && smp_cnt == SMP_END;
    assign par_exp   = (PARITY == 1) ? ~^shreg : ^shreg;
    assign is_break  = bit_cnt == 4'd0 && !vote && shreg == '0 && (PARITY == 0 || !par_bit);
    assign last_stop = state == S_STOP && bit_cnt == 4'(STOP_BITS - 1);
    // Push lands on the same edge the FSM returns to IDLE so the next start edge is never missed.
    assign push      = decide && last_stop && !is_break;
    assign push_word = {frame_err | !vote, parity_err, shreg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            smp_cnt    <= '0;
            bit_cnt    <= '0;
            smp_a      <= 1'b1;
            smp_b      <= 1'b1;
            shreg      <= '0;
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            break_det <= 1'b0;
            if (tick && state != S_IDLE) begin
                smp_cnt <= (smp_cnt == SMP_END) ? '0 : smp_cnt + 1'b1;
                if (smp_cnt == SMP_A) smp_a <= rx_s;
                if (smp_cnt == SMP_B) smp_b <= rx_s;
            end
            case (state)
                S_IDLE: if (tick && !rx_s) begin
                    state      <= S_START;
                    smp_cnt    <= '0;
                    parity_err <= 1'b0;
                    frame_err  <= 1'b0;
                    busy       <= 1'b1;
                end
                S_START: if (decide && vote) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end else if (bit_end) begin
                    state   <= S_DATA;
                    bit_cnt <= '0;
                end
                S_DATA: begin
                    if (decide) shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                            bit_cnt <= '0;
                        end
                    end
                end
                S_PARITY: begin
                    if (decide) begin
                        par_bit    <= vote;
                        parity_err <= vote != par_exp;
                    end
                    if (bit_end) state <= S_STOP;
                end
                S_STOP: begin
                    if (decide) begin
                        if (is_break) begin
                            state     <= S_BREAK;
                            break_det <= 1'b1;
                        end else if (last_stop) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= frame_err | !vote;
                        end
                    end else if (bit_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_BREAK: if (tick && rx_s) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [WW-1:0] head;
    logic          full, pop, do_push;

    assign fifo_count   = wr_ptr - rd_ptr;
    assign m_valid      = wr_ptr != rd_ptr;
    assign full         = fifo_count == DEPTH_L;
    assign pop          = m_valid && m_ready;
    assign do_push      = push && (!full || pop);
    assign head         = mem[rd_ptr[AW-1:0]];
    // Head is masked when empty so stale RAM contents never reach the consumer.
    assign m_data       = m_valid ? head[DATA_BITS-1:0] : '0;
    assign m_parity_err = m_valid & head[DATA_BITS];
    assign m_frame_err  = m_valid & head[DATA_BITS+1];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            overrun <= push && full && !pop;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 and an 8E2 instance driven with directed and random frames,
// checked against a frame-level model (expected word queue, break and overrun tallies).
module tb_uart_rx_fifo;
    localparam int CF       = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int OS       = 8;
    localparam int TICK_DIV = CF / (BAUD * OS);
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic       clk, rst;
    logic       rx [2];
    logic       m_ready [2];
    logic [7:0] m_data [2];
    logic       m_parity_err [2], m_frame_err [2], m_valid [2];
    logic [4:0] fifo_count [2];
    logic       overrun [2], break_det [2], busy [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        uart_rx_fifo #(
            .CLOCK_FREQ(CF), .BAUD(BAUD), .DATA_BITS(8), .PARITY(gi == 1 ? 2 : 0),
            .STOP_BITS(gi + 1), .OVERSAMPLE(OS), .FIFO_DEPTH(16)
        ) u_dut (
            .clk(clk), .rst(rst), .rx(rx[gi]),
            .m_data(m_data[gi]), .m_parity_err(m_parity_err[gi]), .m_frame_err(m_frame_err[gi]),
            .m_valid(m_valid[gi]), .m_ready(m_ready[gi]), .fifo_count(fifo_count[gi]),
            .overrun(overrun[gi]), .break_det(break_det[gi]), .busy(busy[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vec_count = 0;
    int         err_count = 0;
    logic [9:0] exp_q [2][$];
    int         exp_brk [2] = '{0, 0};
    int         exp_ovr [2] = '{0, 0};
    int         brk_cnt [2] = '{0, 0};
    int         ovr_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (break_det[i]) brk_cnt[i]++;
            if (overrun[i]) ovr_cnt[i]++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec_count++;
        if (got !== want) begin
            err_count++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic idle(input int nbits);
        repeat (nbits * BIT_CLKS) @(negedge clk);
    endtask

    // Expected outcome comes straight from the frame contents; the model is updated before the
    // line is driven so it is always ahead of the DUT.
    task automatic send_frame(input int u, input logic [7:0] d, input logic par_flip,
                              input logic [1:0] stop_v, input bit mdl);
        logic [11:0] bits;
        int          nb;
        logic        par, fe, pe, brk;
        par = (^d) ^ par_flip;
        if (u == 0) begin
            bits = {2'b11, stop_v[0], d, 1'b0};
            nb   = 10;
        end else begin
            bits = {stop_v[1], stop_v[0], par, d, 1'b0};
            nb   = 12;
        end
        fe  = !stop_v[0] || (u == 1 && !stop_v[1]);
        pe  = (u == 1) && par_flip;
        brk = (d == 8'h00) && (u == 0 || !par) && !stop_v[0];
        if (mdl) begin
            if (brk) exp_brk[u]++;
            else if (exp_q[u].size() == 16) exp_ovr[u]++;
            else exp_q[u].push_back({fe, pe, d});
        end
        $display("tx u%0d data=%02h par_flip=%0d stop=%b break=%0d", u, d, par_flip, stop_v, brk);
        for (int i = 0; i < nb; i++) begin
            rx[u] = bits[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx[u] = 1'b1;
    endtask

    task automatic drain(input int u);
        int         n;
        logic [9:0] want;
        n = exp_q[u].size();
        check_val($sformatf("u%0d count before drain", u), 32'(fifo_count[u]), n);
        m_ready[u] = 1'b1;
        for (int k = 0; k < n; k++) begin
            want = exp_q[u].pop_front();
            check_val($sformatf("u%0d word %0d", u, k),
                      {m_valid[u], m_frame_err[u], m_parity_err[u], m_data[u]}, {1'b1, want});
            @(negedge clk);
        end
        m_ready[u] = 1'b0;
        check_val($sformatf("u%0d empty after drain", u), {m_valid[u], fifo_count[u]}, 0);
    endtask

    task automatic check_pulses(input int u);
        check_val($sformatf("u%0d break pulses", u), brk_cnt[u], exp_brk[u]);
        check_val($sformatf("u%0d overrun pulses", u), ovr_cnt[u], exp_ovr[u]);
    endtask

    task automatic check_quiet(input int u, input string tag);
        check_val($sformatf("u%0d %s", u, tag),
                  {m_valid[u], busy[u], overrun[u], break_det[u], m_parity_err[u],
                   m_frame_err[u], fifo_count[u], m_data[u]}, 0);
    endtask

    initial begin
        #(90_000 * 10);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int         w, nf;
    logic [7:0] d;
    logic       pf;
    logic [1:0] sv;

    initial begin
        rst = 1'b1;
        rx = '{1'b1, 1'b1};
        m_ready = '{1'b0, 1'b0};
        repeat (4) @(negedge clk);
        check_quiet(0, "reset state");
        check_quiet(1, "reset state");
        rst = 1'b0;
        idle(2);

        // 8N1 basic word, visible by the end of the stop bit
        send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b1);
        check_val("u0 valid at stop end", m_valid[0], 1);
        drain(0);
        idle(1);

        // even parity: bad then good parity bit
        send_frame(1, 8'h07, 1'b1, 2'b11, 1'b1); idle(1);
        send_frame(1, 8'h07, 1'b0, 2'b11, 1'b1); idle(1);
        drain(1);

        // second stop bit low, then a clean frame
        send_frame(1, 8'h3C, 1'b0, 2'b01, 1'b1); idle(1);
        send_frame(1, 8'h11, 1'b0, 2'b11, 1'b1); idle(1);
        drain(1);

        // short low glitch is rejected
        rx[0] = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        rx[0] = 1'b1;
        idle(2);
        check_val("u0 busy after glitch", busy[0], 0);
        check_val("u0 count after glitch", 32'(fifo_count[0]), 0);
        send_frame(0, 8'h5A, 1'b0, 2'b11, 1'b1); idle(1);
        drain(0);

        // fill to 16, the 17th word overruns
        for (int i = 0; i < 17; i++) begin
            send_frame(0, 8'(i), 1'b0, 2'b11, 1'b1);
            idle(1);
        end
        check_val("u0 count full", 32'(fifo_count[0]), 16);
        check_pulses(0);
        drain(0);

        // full FIFO with push and pop on the same edge
        for (int i = 0; i < 16; i++) begin
            send_frame(0, 8'h20 + 8'(i), 1'b0, 2'b11, 1'b1);
            idle(1);
        end
        fork
            send_frame(0, 8'h30, 1'b0, 2'b11, 1'b0);
            begin
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!busy[0] && w < 40);
                check_val("u0 start detected", busy[0], 1);
                repeat (2 * (8 * 9 + 6) - 1) @(negedge clk);
                check_val("u0 busy before push", busy[0], 1);
                check_val("u0 full head", {m_valid[0], m_frame_err[0], m_parity_err[0], m_data[0]},
                          {1'b1, exp_q[0].pop_front()});
                m_ready[0] = 1'b1;
                @(negedge clk);
                m_ready[0] = 1'b0;
                check_val("u0 busy after push", busy[0], 0);
                check_val("u0 count push+pop", 32'(fifo_count[0]), 16);
            end
        join
        exp_q[0].push_back(10'h030);
        idle(1);
        check_pulses(0);
        drain(0);

        // two frame times of low line
        rx[0] = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        rx[0] = 1'b1;
        exp_brk[0]++;
        idle(2);
        check_pulses(0);
        check_quiet(0, "after break");
        send_frame(0, 8'hC3, 1'b0, 2'b11, 1'b1); idle(1);
        drain(0);

        // reset in the middle of a frame with a word already queued
        send_frame(0, 8'h77, 1'b0, 2'b11, 1'b1); idle(1);
        rx[0] = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check_val("u0 busy mid-frame", busy[0], 1);
        rx[0] = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet(0, "mid-frame reset");
        check_quiet(1, "mid-frame reset");
        rst = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        idle(1);
        send_frame(0, 8'hE1, 1'b0, 2'b11, 1'b1); idle(1);
        drain(0);

        // random traffic on both instances
        for (int u = 0; u < 2; u++) begin
            for (int b = 0; b < 3; b++) begin
                nf = $urandom_range(4, 12);
                for (int f = 0; f < nf; f++) begin
                    d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                    pf = ($urandom_range(0, 3) == 0);
                    sv = {1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 5) != 0)};
                    send_frame(u, d, pf, sv, 1'b1);
                    idle($urandom_range(1, 3));
                end
                check_pulses(u);
                drain(u);
            end
        end

        check_pulses(0);
        check_pulses(1);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule
